pixel_reorder_engine: RTL and testbench

PIXEL_REORDER_ENGINE -- requirements
Module: pixel_reorder_engine

---
 rtl/pixel_reorder_pkg.sv | 28 ++
 rtl/reorder_channel_bank.sv | 46 ++++
 rtl/pixel_reorder_engine.sv | 152 +++++++++++++++
 tb/tb_pixel_reorder_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_reorder_pkg.sv
// Shared definitions for the pixel reorder engine.
//   state_t     : FSM state encoding (IDLE, READ, WRITE, DONE)
//   PERM_W      : width of one permutation field (channel index)
//   MAX_NCH     : largest supported channel count
//   perm_field(): extracts output slot's source-channel index from a perm vector
package pixel_reorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PERM_W     = 3;
  localparam int MAX_NCH    = 8;
  localparam int PERM_VEC_W = PERM_W * MAX_NCH;

  // Callers zero-extend their NCH*PERM_W vector to PERM_VEC_W so one
  // function serves every legal channel count.
  function automatic logic [PERM_W-1:0] perm_field(
    input logic [PERM_VEC_W-1:0] vec,
    input logic [PERM_W-1:0]     slot
  );
    return vec[slot*PERM_W +: PERM_W];
  endfunction

endpackage

// File: rtl/reorder_channel_bank.sv
// Holds the channel samples of the pixel being processed and selects the one
// routed to the write port.
//   clk, rst : clock, synchronous active-high reset
//   cap_en   : rd_data carries channel cap_idx this cycle
//   cap_idx  : channel index being returned by memory
//   rd_data  : memory read data
//   sel      : source channel for the current output slot
//   data     : selected sample; zero when sel >= NCH
module reorder_channel_bank
  import pixel_reorder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_en,
  input  logic [PERM_W-1:0]   cap_idx,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic [PERM_W-1:0]   sel,
  output logic [DATA_W-1:0]   data
);

  logic [DATA_W-1:0] ch [NCH];

  // NOTE: the channel array is small register storage, not RAM, so it is
  // cleared by reset like any other flop and never shows stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ch[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NCH; i++)
        if (cap_idx == PERM_W'(i)) ch[i] <= rd_data;
    end
  end

  // A channel arriving this cycle is forwarded straight from rd_data; this
  // only matters for the last channel, which lands during write slot 0.
  always_comb begin
    data = '0;
    for (int i = 0; i < NCH; i++)
      if (sel == PERM_W'(i))
        data = (cap_en && cap_idx == sel) ? rd_data : ch[i];
  end

endmodule

// File: rtl/pixel_reorder_engine.sv
// Reads each pixel's NCH channel samples from memory and writes them back to
// a destination buffer in the channel order given by perm.
//   clk, rst                  : clock, synchronous active-high reset
//   start, abort              : job control
//   pixel_count, src_base,
//   dst_base, perm            : job parameters, latched when start is accepted
//   rd_en, rd_addr, rd_data   : memory read port (data one cycle after rd_en)
//   wr_en, wr_addr, wr_data   : memory write port
//   busy, done                : job in progress / one-cycle completion pulse
module pixel_reorder_engine
  import pixel_reorder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      pixel_count,
  input  logic [ADDR_W-1:0]      src_base,
  input  logic [ADDR_W-1:0]      dst_base,
  input  logic [NCH*PERM_W-1:0]  perm,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [PERM_W-1:0] LAST_SLOT = PERM_W'(NCH - 1);

  state_t                state_q, state_d;
  logic [PERM_W-1:0]     slot_q;
  logic [ADDR_W-1:0]     pix_q, count_q;
  logic [ADDR_W-1:0]     rd_base_q, wr_base_q;   // base + pix*NCH, kept incrementally
  logic [NCH*PERM_W-1:0] perm_q;
  logic                  cap_en_q;
  logic [PERM_W-1:0]     cap_idx_q;
  logic [PERM_W-1:0]     sel;
  logic [DATA_W-1:0]     bank_data;
  logic                  slot_last, pix_last;

  assign slot_last = (slot_q == LAST_SLOT);
  assign pix_last  = (pix_q == count_q - ADDR_W'(1));
  assign sel       = perm_field(PERM_VEC_W'(perm_q), slot_q);

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output and next-state value is defaulted first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (pixel_count != '0) ? ST_READ : ST_DONE;
      end
      ST_READ: begin
        rd_en   = 1'b1;
        busy    = 1'b1;
        rd_addr = rd_base_q + ADDR_W'(slot_q);
        if (abort)          state_d = ST_IDLE;
        else if (slot_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        wr_addr = wr_base_q + ADDR_W'(slot_q);
        wr_data = bank_data;
        if (abort)          state_d = ST_IDLE;
        else if (slot_last) state_d = pix_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job parameters, slot/pixel counters and the read-return pipeline tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      pix_q     <= '0;
      count_q   <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      perm_q    <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      // rd_data returns one cycle after the strobe, tagged with its channel.
      cap_en_q  <= (state_q == ST_READ);
      cap_idx_q <= slot_q;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            count_q   <= pixel_count;
            rd_base_q <= src_base;
            wr_base_q <= dst_base;
            perm_q    <= perm;
            pix_q     <= '0;
            slot_q    <= '0;
          end
        end
        ST_READ: begin
          slot_q <= slot_last ? '0 : slot_q + PERM_W'(1);
        end
        ST_WRITE: begin
          slot_q <= slot_last ? '0 : slot_q + PERM_W'(1);
          if (slot_last) begin
            pix_q     <= pix_q + ADDR_W'(1);
            rd_base_q <= rd_base_q + ADDR_W'(NCH);
            wr_base_q <= wr_base_q + ADDR_W'(NCH);
          end
        end
        default: ;
      endcase
    end
  end

  reorder_channel_bank #(
    .DATA_W (DATA_W),
    .NCH    (NCH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en_q),
    .cap_idx (cap_idx_q),
    .rd_data (rd_data),
    .sel     (sel),
    .data    (bank_data)
  );

endmodule

// File: tb/tb_pixel_reorder_engine.sv
// Self-checking bench: a job-level model expands each accepted job into the
// cycle-by-cycle output trace it must produce; one compare process checks the
// DUT outputs against that trace (or against all-zero when idle) every cycle.
module tb_pixel_reorder_engine;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int AW  = 16;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [AW-1:0]   pixel_count = '0;
  logic [AW-1:0]   src_base = '0;
  logic [AW-1:0]   dst_base = '0;
  logic [NCH*3-1:0] perm = '0;
  logic [DW-1:0]   rd_data = '0;
  logic            rd_en, wr_en, busy, done;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [DW-1:0]   wr_data;

  pixel_reorder_engine #(.DATA_W(DW), .NCH(NCH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pixel_count(pixel_count), .src_base(src_base), .dst_base(dst_base),
    .perm(perm), .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem  [1 << AW];   // source contents, written only by the stimulus
  logic [DW-1:0] wmem [1 << AW];   // what the DUT wrote
  obs_t          exp_q [$];
  logic [AW-1:0] rd_log [$];
  int            busy_cnt = 0, done_cnt = 0, strobe_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: a read strobe seen in one cycle returns data in the next;
  // outside that slot rd_data carries random junk.
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0;
  always @(negedge clk) begin
    rd_pend      <= rd_en;
    rd_pend_addr <= rd_addr;
    if (wr_en) wmem[wr_addr] = wr_data;
  end
  always @(posedge clk) rd_data <= rd_pend ? mem[rd_pend_addr] : DW'($urandom);

  // Cycle compare against the model trace.
  always @(negedge clk) begin
    obs_t act, exp;
    act = '{rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done};
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("cycle_outputs", 64'(act), 64'(exp));
    busy_cnt   += int'(busy);
    done_cnt   += int'(done);
    strobe_cnt += int'(rd_en | wr_en);
    if (rd_en) rd_log.push_back(rd_addr);
  end

  // Job model: NCH reads then NCH permuted writes per pixel, then one DONE cycle.
  task automatic push_job(input int cnt, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [NCH*3-1:0] pm);
    obs_t e;
    for (int p = 0; p < cnt; p++) begin
      for (int k = 0; k < NCH; k++) begin
        e = '0; e.rd_en = 1'b1; e.busy = 1'b1;
        e.rd_addr = src + AW'(p * NCH + k);
        exp_q.push_back(e);
      end
      for (int s = 0; s < NCH; s++) begin
        int f;
        f = int'(pm[s*3 +: 3]);
        e = '0; e.wr_en = 1'b1; e.busy = 1'b1;
        e.wr_addr = dst + AW'(p * NCH + s);
        e.wr_data = (f < NCH) ? mem[src + AW'(p * NCH + f)] : '0;
        exp_q.push_back(e);
      end
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Issues start in an idle cycle; returns #1 into the first cycle of the job
  // with the job inputs scrambled to prove they were latched.
  task automatic do_start(input int cnt, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [NCH*3-1:0] pm);
    @(posedge clk); #1;
    start = 1'b1; pixel_count = AW'(cnt); src_base = src; dst_base = dst; perm = pm;
    @(posedge clk); #1;
    start = 1'b0;
    pixel_count = AW'($urandom); src_base = AW'($urandom);
    dst_base = AW'($urandom); perm = (NCH*3)'($urandom);
    push_job(cnt, src, dst, pm);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check({name, "_timeout"}, 64'(n < 300), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; strobe_cnt = 0; rd_log.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[16'h0000] = 8'd11; mem[16'h0001] = 8'd22; mem[16'h0002] = 8'd33;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_idle", 64'({rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}), 64'(0));

    // Single pixel, perm {1,0,2}: done lands 7 cycles after acceptance.
    clear_counts();
    do_start(1, 16'h0000, 16'h0100, {3'd2, 3'd0, 3'd1});
    check("model_w0", 64'(exp_q[3].wr_data), 64'd22);
    check("model_done_pos", 64'(exp_q[6].done), 64'd1);
    wait_drain("job1");
    check("job1_0100", 64'(wmem[16'h0100]), 64'd22);
    check("job1_0101", 64'(wmem[16'h0101]), 64'd11);
    check("job1_0102", 64'(wmem[16'h0102]), 64'd33);
    check("job1_done_cnt", 64'(done_cnt), 64'd1);

    // Four pixels channel-reversed (slot 0 reads channel 2: bypass path).
    clear_counts();
    do_start(4, 16'h0200, 16'h0300, {3'd0, 3'd1, 3'd2});
    wait_drain("job4");
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < NCH; s++)
        check("job4_rev", 64'(wmem[16'h0300 + AW'(p*NCH + s)]),
              64'(mem[16'h0200 + AW'(p*NCH + NCH - 1 - s)]));
    check("job4_busy_cycles", 64'(busy_cnt), 64'd24);
    check("job4_done_cnt", 64'(done_cnt), 64'd1);

    // Zero-pixel job: done only, no strobes.
    clear_counts();
    do_start(0, 16'h0400, 16'h0500, {3'd2, 3'd1, 3'd0});
    wait_drain("job0");
    check("job0_strobes", 64'(strobe_cnt), 64'd0);
    check("job0_done_cnt", 64'(done_cnt), 64'd1);

    // Source address wrap; slot 2 field out of range writes zero.
    clear_counts();
    do_start(1, 16'hFFFE, 16'h0600, {3'd7, 3'd0, 3'd1});
    wait_drain("wrap");
    check("wrap_rd0", 64'(rd_log[0]), 64'hFFFE);
    check("wrap_rd1", 64'(rd_log[1]), 64'hFFFF);
    check("wrap_rd2", 64'(rd_log[2]), 64'h0000);
    check("wrap_zero_slot", 64'(wmem[16'h0602]), 64'd0);

    // Abort in the 2nd write cycle of pixel 1 of 3.
    clear_counts();
    do_start(3, 16'h0700, 16'h0800, {3'd1, 3'd2, 3'd0});
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    clear_counts();
    do_start(2, 16'h0900, 16'h0A00, {3'd0, 3'd0, 3'd2});
    wait_drain("post_abort");
    check("post_abort_done", 64'(done_cnt), 64'd1);

    // Reset mid-READ with a start held alongside it.
    do_start(2, 16'h0B00, 16'h0C00, {3'd2, 3'd0, 3'd1});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    start = 1'b1; pixel_count = 16'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'({rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}), 64'(0));

    // Start pulse during WRITE is ignored.
    clear_counts();
    do_start(2, 16'h0D00, 16'h0E00, {3'd1, 3'd2, 3'd0});
    repeat (4) @(posedge clk);
    #1 start = 1'b1; pixel_count = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_drain("start_in_write");
    repeat (4) @(posedge clk);
    #1;
    check("start_in_write_busy", 64'(busy_cnt), 64'd12);

    // Randomised jobs.
    for (int j = 0; j < 10; j++) begin
      logic [AW-1:0] s;
      s = AW'($urandom);
      do_start(int'($urandom_range(0, 5)), s, s ^ 16'h8000, (NCH*3)'($urandom));
      wait_drain("rand_job");
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
